slow_clock_bank: RTL and testbench

SLOW_CLOCK_BANK -- requirements
Module: slow_clock_bank

---
 rtl/slow_clock_bank_pkg.sv | 12 +
 rtl/slow_clock_channel.sv | 95 +++++++++
 rtl/slow_clock_bank.sv | 61 ++++++
 tb/tb_slow_clock_bank.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/slow_clock_bank_pkg.sv
// Shared constants and helpers for the slow clock bank.
package slow_clock_bank_pkg;

  // Factor loaded into every channel at reset (truncated/extended to Width).
  localparam logic [31:0] DEFAULT_FACTOR = 32'h00FF_FFFF;

  // Width of a channel index; never narrower than one bit.
  function automatic int chan_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/slow_clock_channel.sv
// One divided-clock channel: counter, live factor, staged factor and pending flag.
// Optional tick output is built only when SLOW_CLOCK_BANK_TICK_EN is defined.
module slow_clock_channel
  import slow_clock_bank_pkg::*;
#(
  parameter int               Width         = 32,
  parameter logic [Width-1:0] DefaultFactor = Width'(DEFAULT_FACTOR)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             locked_i,
  input  logic             sync_i,
  input  logic             enable_i,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_factor_i,
  output logic             pending_o,
  output logic             outclock_o
`ifdef SLOW_CLOCK_BANK_TICK_EN
  , output logic           tick_o
`endif
);

  logic [Width-1:0] cnt_q, cnt_d;
  logic [Width-1:0] factor_q, factor_d;
  logic [Width-1:0] staged_q, staged_d;
  logic             pending_q, pending_d;
  logic             out_q, out_d;
  logic             clear, terminal;

  // Lock loss and sync both force phase zero.
  assign clear    = !locked_i || sync_i;
  assign terminal = (cnt_q == factor_q);

  // Next-state: count/toggle, then factor staging. A staged factor only lands
  // at a half-period boundary or while the channel is not actually counting,
  // so a running half-period always completes with the factor it started with.
  always_comb begin
    cnt_d     = cnt_q;
    out_d     = out_q;
    factor_d  = factor_q;
    staged_d  = staged_q;
    pending_d = pending_q;
    if (clear) begin
      cnt_d = '0;
      out_d = 1'b0;
    end else if (enable_i) begin
      if (terminal) begin
        cnt_d = '0;
        out_d = ~out_q;
      end else begin
        cnt_d = cnt_q + Width'(1);
      end
    end
    if (pending_q && (clear || !enable_i || terminal)) begin
      factor_d  = staged_q;
      pending_d = 1'b0;
    end else if (wr_en_i) begin
      staged_d  = wr_factor_i;
      pending_d = 1'b1;
    end
  end

  // Channel state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      factor_q  <= DefaultFactor;
      staged_q  <= DefaultFactor;
      pending_q <= 1'b0;
      out_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      factor_q  <= factor_d;
      staged_q  <= staged_d;
      pending_q <= pending_d;
      out_q     <= out_d;
    end
  end

  assign pending_o  = pending_q;
  assign outclock_o = out_q;

`ifdef SLOW_CLOCK_BANK_TICK_EN
  logic tick_q;

  // One-cycle pulse registered with every outclock toggle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) tick_q <= 1'b0;
    else        tick_q <= !clear && enable_i && terminal;
  end

  assign tick_o = tick_q;
`endif

endmodule

// File: rtl/slow_clock_bank.sv
// Bank of NumChannels independent clock dividers sharing one clock.
// Top level decodes the factor-update handshake; channels hold all state.
// Define SLOW_CLOCK_BANK_TICK_EN to add the per-channel tick output.
module slow_clock_bank
  import slow_clock_bank_pkg::*;
#(
  parameter int               NumChannels   = 4,
  parameter int               Width         = 32,
  parameter logic [Width-1:0] DefaultFactor = Width'(DEFAULT_FACTOR),
  localparam int              CW            = chan_idx_w(NumChannels)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   locked,
  input  logic [NumChannels-1:0] enable,
  input  logic                   sync,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [CW-1:0]          wr_channel,
  input  logic [Width-1:0]       wr_factor,
  output logic [NumChannels-1:0] outclock
`ifdef SLOW_CLOCK_BANK_TICK_EN
  , output logic [NumChannels-1:0] tick
`endif
);

  logic [NumChannels-1:0] pending;
  logic [NumChannels-1:0] wr_hit;

  // Ready reflects the addressed channel's pending flag; indices with no
  // channel behind them are always ready and the write simply vanishes.
  always_comb begin
    wr_ready = 1'b1;
    for (int i = 0; i < NumChannels; i++) begin
      if (wr_channel == CW'(i)) wr_ready = ~pending[i];
    end
  end

  for (genvar g = 0; g < NumChannels; g++) begin : g_ch
    assign wr_hit[g] = wr_valid && (wr_channel == CW'(g)) && !pending[g];

    slow_clock_channel #(
      .Width         (Width),
      .DefaultFactor (DefaultFactor)
    ) u_ch (
      .clock       (clock),
      .reset       (reset),
      .locked_i    (locked),
      .sync_i      (sync),
      .enable_i    (enable[g]),
      .wr_en_i     (wr_hit[g]),
      .wr_factor_i (wr_factor),
      .pending_o   (pending[g]),
      .outclock_o  (outclock[g])
`ifdef SLOW_CLOCK_BANK_TICK_EN
      , .tick_o    (tick[g])
`endif
    );
  end

endmodule

// File: tb/tb_slow_clock_bank.sv
// Directed bench for slow_clock_bank (4-channel main instance, 3-channel
// instance for writes to an index with no channel behind it).
module tb_slow_clock_bank;

  logic       clock = 1'b0;
  logic       reset;
  logic       locked, sync, wr_valid, wr_ready;
  logic [3:0] enable, outclock;
  logic [1:0] wr_channel;
  logic [7:0] wr_factor;

  logic       locked3, sync3, wr_valid3, wr_ready3;
  logic [2:0] enable3, outclock3;
  logic [1:0] wr_channel3;
  logic [7:0] wr_factor3;
`ifdef SLOW_CLOCK_BANK_TICK_EN
  logic [3:0] tick;
  logic [2:0] tick3;
`endif

  always #5 clock = ~clock;

  slow_clock_bank #(.NumChannels(4), .Width(8)) u_dut (
    .clock(clock), .reset(reset), .locked(locked), .enable(enable), .sync(sync),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_channel(wr_channel),
    .wr_factor(wr_factor), .outclock(outclock)
`ifdef SLOW_CLOCK_BANK_TICK_EN
    , .tick(tick)
`endif
  );

  slow_clock_bank #(.NumChannels(3), .Width(8), .DefaultFactor(8'd1)) u_dut3 (
    .clock(clock), .reset(reset), .locked(locked3), .enable(enable3), .sync(sync3),
    .wr_valid(wr_valid3), .wr_ready(wr_ready3), .wr_channel(wr_channel3),
    .wr_factor(wr_factor3), .outclock(outclock3)
`ifdef SLOW_CLOCK_BANK_TICK_EN
    , .tick(tick3)
`endif
  );

  typedef struct {
    bit         lk;
    bit         sy;
    logic [3:0] en;
    bit         wv;
    logic [1:0] wch;
    logic [7:0] wf;
    bit         rdy;
    logic [3:0] out;
  } vec_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] last_out = 4'h0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Apply one vector: check ready with the inputs applied, then the outputs
  // registered on the following edge.
  task automatic cyc(input vec_t v, input string nm);
    locked = v.lk; sync = v.sy; enable = v.en;
    wr_valid = v.wv; wr_channel = v.wch; wr_factor = v.wf;
    #1;
    check({nm, ".rdy"}, 32'(wr_ready), 32'(v.rdy));
    @(posedge clock); #1;
    check({nm, ".out"}, 32'(outclock), 32'(v.out));
`ifdef SLOW_CLOCK_BANK_TICK_EN
    check({nm, ".tick"}, 32'(tick),
          32'((v.out ^ last_out) & ((v.lk && !v.sy) ? 4'hF : 4'h0)));
`endif
    last_out = v.out;
  endtask

  vec_t tbl[18];
  vec_t v;
  logic [3:0] e;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; locked = 1'b0; sync = 1'b0; enable = 4'h0;
    wr_valid = 1'b0; wr_channel = 2'd0; wr_factor = 8'd0;
    locked3 = 1'b0; sync3 = 1'b0; enable3 = 3'h0;
    wr_valid3 = 1'b0; wr_channel3 = 2'd0; wr_factor3 = 8'd0;

    // Startup: bring-up writes with channels idle, then run at factor 3.
    tbl[0]  = '{1, 0, 4'h0, 1, 2'd0, 8'd3, 1, 4'h0};
    tbl[1]  = '{1, 0, 4'h0, 1, 2'd1, 8'd3, 1, 4'h0};
    tbl[2]  = '{1, 0, 4'h0, 1, 2'd1, 8'd9, 0, 4'h0};  // stalled: ch1 pending
    tbl[3]  = '{1, 0, 4'h0, 1, 2'd2, 8'd3, 1, 4'h0};
    tbl[4]  = '{1, 0, 4'h0, 1, 2'd3, 8'd3, 1, 4'h0};
    tbl[5]  = '{1, 0, 4'h0, 0, 2'd3, 8'd0, 0, 4'h0};
    tbl[6]  = '{1, 0, 4'hF, 0, 2'd0, 8'd0, 1, 4'h0};
    tbl[7]  = '{1, 0, 4'hF, 0, 2'd0, 8'd0, 1, 4'h0};
    tbl[8]  = '{1, 0, 4'hF, 0, 2'd0, 8'd0, 1, 4'h0};
    tbl[9]  = '{1, 0, 4'hF, 0, 2'd0, 8'd0, 1, 4'hF};
    tbl[10] = '{1, 0, 4'hF, 0, 2'd0, 8'd0, 1, 4'hF};
    tbl[11] = '{1, 0, 4'hF, 0, 2'd0, 8'd0, 1, 4'hF};
    tbl[12] = '{1, 0, 4'hF, 0, 2'd0, 8'd0, 1, 4'hF};
    tbl[13] = '{1, 0, 4'hF, 0, 2'd0, 8'd0, 1, 4'h0};
    tbl[14] = '{1, 0, 4'hF, 0, 2'd0, 8'd0, 1, 4'h0};
    tbl[15] = '{1, 0, 4'hF, 0, 2'd0, 8'd0, 1, 4'h0};
    tbl[16] = '{1, 0, 4'hF, 0, 2'd0, 8'd0, 1, 4'h0};
    tbl[17] = '{1, 0, 4'hF, 0, 2'd0, 8'd0, 1, 4'hF};

    // Reset state.
    repeat (2) @(posedge clock);
    #1;
    check("rst.out", 32'(outclock), 32'h0);
    check("rst.rdy", 32'(wr_ready), 32'h1);
    reset = 1'b1;

    for (int i = 0; i < 18; i++) cyc(tbl[i], $sformatf("tbl%0d", i));

    // Factor 0 on ch1 (loaded while ch1 idles at cnt 0), then freeze/resume.
    cyc('{1, 0, 4'hD, 1, 2'd1, 8'd0, 1, 4'hF}, "a1");
    cyc('{1, 0, 4'hD, 0, 2'd1, 8'd0, 0, 4'hF}, "a2");
    cyc('{1, 0, 4'hF, 0, 2'd0, 8'd0, 1, 4'hD}, "a3");
    cyc('{1, 0, 4'hF, 0, 2'd0, 8'd0, 1, 4'h2}, "a4");
    cyc('{1, 0, 4'hF, 0, 2'd0, 8'd0, 1, 4'h0}, "a5");
    cyc('{1, 0, 4'hD, 0, 2'd0, 8'd0, 1, 4'h0}, "a6");
    cyc('{1, 0, 4'hD, 0, 2'd0, 8'd0, 1, 4'h0}, "a7");
    cyc('{1, 0, 4'hF, 0, 2'd0, 8'd0, 1, 4'hF}, "a8");
    cyc('{1, 0, 4'hF, 0, 2'd0, 8'd0, 1, 4'hD}, "a9");

    // Sync with phases differing; ch2 gets factor 9 while synced.
    cyc('{1, 1, 4'hF, 1, 2'd2, 8'd9, 1, 4'h0}, "b0");
    cyc('{1, 1, 4'hF, 0, 2'd2, 8'd0, 0, 4'h0}, "b1");
    // ch2: write factor 1 at cnt 4; a second write while pending is stalled.
    for (int k = 1; k <= 16; k++) begin
      e[0] = 1'((k / 4) & 1);
      e[1] = 1'(k & 1);
      e[2] = (k >= 10) ? ~1'(((k - 10) / 2) & 1) : 1'b0;
      e[3] = e[0];
      v = '{1, 0, 4'hF, (k == 5 || k == 6), 2'd2, (k == 5) ? 8'd1 : 8'd5,
            !(k >= 6 && k <= 10), e};
      cyc(v, $sformatf("b_e%0d", k));
    end

    // One cycle of lock loss (enable low too), then in-phase restart.
    cyc('{0, 0, 4'h0, 0, 2'd2, 8'd0, 1, 4'h0}, "d0");
    for (int k = 1; k <= 9; k++) begin
      e[0] = 1'((k / 4) & 1);
      e[1] = 1'(k & 1);
      e[2] = 1'((k / 2) & 1);
      e[3] = e[0];
      v = '{1, 0, 4'hF, 0, 2'd2, 8'd0, 1, e};
      cyc(v, $sformatf("d_k%0d", k));
    end

    // Asynchronous reset mid-run, then default factor 0xFF counts to terminal.
    reset = 1'b0;
    #1;
    check("rst_async.out", 32'(outclock), 32'h0);
    @(posedge clock); #1;
    reset = 1'b1; locked = 1'b1; sync = 1'b0; enable = 4'h1; wr_valid = 1'b0;
    for (int k = 1; k <= 256; k++) begin
      @(posedge clock); #1;
      if (k == 255 || k == 256) begin
        check($sformatf("dflt_k%0d.out0", k), 32'(outclock[0]), (k == 256) ? 32'h1 : 32'h0);
`ifdef SLOW_CLOCK_BANK_TICK_EN
        check($sformatf("dflt_k%0d.tick0", k), 32'(tick[0]), (k == 256) ? 32'h1 : 32'h0);
`endif
      end
    end

    // Three-channel bank: writes to index 3 are accepted and discarded.
    locked = 1'b0;
    locked3 = 1'b1; enable3 = 3'h7; wr_valid3 = 1'b1; wr_channel3 = 2'd3; wr_factor3 = 8'd0;
    for (int k = 1; k <= 6; k++) begin
      #1;
      check($sformatf("oor_k%0d.rdy", k), 32'(wr_ready3), 32'h1);
      @(posedge clock); #1;
      check($sformatf("oor_k%0d.out", k), 32'(outclock3),
            ((k / 2) & 1) ? 32'h7 : 32'h0);
`ifdef SLOW_CLOCK_BANK_TICK_EN
      check($sformatf("oor_k%0d.tick", k), 32'(tick3), ((k & 1) == 0) ? 32'h7 : 32'h0);
`endif
    end
    wr_valid3 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
